// File: rtl/sub_chain_16bit.sv
// Registered multi-precision subtractor: streams limb pairs LS-first over valid/ready
// and produces A - B - bin one limb per cycle, carrying the borrow between limbs.

// state | meaning
// IDLE  | waiting for the first limb of an operation
// BUSY  | mid-operation, borrow register holds the previous limb's borrow-out
module sub_chain_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_last,
    output logic             overflow,
    output logic             zero,
    output logic             proto_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    logic           borrow_q;
    logic           zacc_q;

    logic           accept;
    logic           start;
    logic           borrow_in;
    logic           frame_err;
    logic           diff_is_zero;
    logic           zacc_next;
    logic           ovf_next;
    logic [WIDTH:0] sub_full;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A stray non-first limb in IDLE is treated as the start of a new operation.
    assign start     = in_first || (state == IDLE);
    assign borrow_in = start ? bin : borrow_q;
    assign sub_full  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};

    assign frame_err    = (state == IDLE) ? !in_first : in_first;
    assign diff_is_zero = (sub_full[WIDTH-1:0] == '0);
    assign zacc_next    = start ? diff_is_zero : (zacc_q && diff_is_zero);
    assign ovf_next     = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            borrow_q  <= 1'b0;
            zacc_q    <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            if (accept) begin
                state     <= in_last ? IDLE : BUSY;
                borrow_q  <= sub_full[WIDTH];
                zacc_q    <= zacc_next;
                out_valid <= 1'b1;
                diff      <= sub_full[WIDTH-1:0];
                bout      <= sub_full[WIDTH];
                out_last  <= in_last;
                overflow  <= in_last && ovf_next;
                zero      <= in_last && zacc_next;
                proto_err <= frame_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_chain_16bit.sv
// Self-checking bench for sub_chain_16bit: table of limb vectors with expected results,
// replayed with and without backpressure through a scoreboard queue, plus stall and reset sequences.

module tb_sub_chain_16bit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic        in_last;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        out_last;
    logic        overflow;
    logic        zero;
    logic        proto_err;

    typedef struct {
        logic        first;
        logic        last;
        logic        bin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks;
    int   errors;
    int   mode;        // 0: out_ready=1, 1: random, 2: held low
    bit   will_accept;

    sub_chain_16bit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .out_last  (out_last),
        .overflow  (overflow),
        .zero      (zero),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic f, input logic l, input logic bi,
                                input logic [15:0] aa, input logic [15:0] bb,
                                input logic [15:0] dd, input logic bo, input logic ov,
                                input logic z, input logic e);
        vec_t v;
        v.first = f; v.last = l; v.bin = bi; v.a = aa; v.b = bb;
        v.diff = dd; v.bout = bo; v.ovf = ov; v.zero = z; v.err = e;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input vec_t v);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_first = v.first;
        in_last  = v.last;
        bin      = v.bin;
        a        = v.a;
        b        = v.b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        if (ok) exp_q.push_back(v);
        else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: limb a=%h b=%h not accepted in 200 cycles", v.a, v.b);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    task automatic monitor();
        vec_t h;
        bit   fresh;
        forever begin
            @(negedge clk);
            fresh       = will_accept;
            will_accept = 1'b0;
            if (!rst) begin
                chk1("in_ready", in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: got diff=%h expected no output", diff);
                    end else begin
                        h = exp_q[0];
                        chk16("diff", diff, h.diff);
                        chk1("bout", bout, h.bout);
                        chk1("out_last", out_last, h.last);
                        chk1("overflow", overflow, h.ovf);
                        chk1("zero", zero, h.zero);
                        chk1("proto_err", proto_err, fresh ? h.err : 1'b0);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk1("proto_err_idle", proto_err, 1'b0);
                end
                will_accept = in_valid && in_ready;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mode        = 0;
        will_accept = 1'b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_first    = 1'b0;
        in_last     = 1'b0;
        a           = '0;
        b           = '0;
        bin         = 1'b0;
        out_ready   = 1'b1;

        //                f  l  bin a        b        diff     bo ov z  e
        vecs.push_back(mk(1, 1, 0, 16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0001, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h5678, 16'h5678, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h1234, 16'h1234, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 16'h5678, 16'h5678, 16'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h1234, 16'h1234, 16'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h7FFF, 16'hFFFF, 16'h8000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0010, 16'h0001, 16'h000E, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0003, 16'h0001, 16'h0002, 0, 0, 0, 1));

        fork
            monitor();
            ready_driver();
        join_none

        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_diff", diff, 16'h0000);
        chk1("rst_bout", bout, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full throughput, then random backpressure
        foreach (vecs[i]) send(vecs[i]);
        mode = 1;
        foreach (vecs[i]) send(vecs[i]);
        mode      = 0;
        out_ready = 1'b1;
        drain();

        // 3-cycle stall with the next limb waiting
        mode      = 2;
        out_ready = 1'b0;
        send(mk(1, 0, 0, 16'h5678, 16'h5678, 16'h0000, 0, 0, 0, 0));
        fork
            send(mk(0, 1, 0, 16'h1234, 16'h1234, 16'h0000, 0, 0, 1, 0));
            begin
                repeat (3) @(posedge clk);
                #2;
                mode      = 0;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of an operation with a held output
        mode      = 2;
        out_ready = 1'b0;
        send(mk(1, 0, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk16("midrst_diff", diff, 16'h0000);
        chk1("midrst_bout", bout, 1'b0);
        chk1("midrst_out_last", out_last, 1'b0);
        chk1("midrst_proto_err", proto_err, 1'b0);
        exp_q.delete();
        will_accept = 1'b0;
        @(posedge clk);
        #3;
        rst       = 1'b0;
        mode      = 0;
        out_ready = 1'b1;
        send(mk(1, 1, 0, 16'h0003, 16'h0001, 16'h0002, 0, 0, 0, 0));
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: got %0d pending results expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
